// File: rtl/ddr2_wdata_tx.sv
// DDR2 write-data transmitter: drives one preamble/burst/postamble sequence on dq/dqs/dm
// per accepted write command, fetching one word per beat from the write-data FIFO.
module ddr2_wdata_tx #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned WL_W      = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [WL_W-1:0]     i_cmd_wl,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wmask,
  input  logic                i_wdata_valid,
  output logic                o_wdata_ready,
  output logic [DATA_W-1:0]   o_dq,
  output logic [DATA_W/8-1:0] o_dm,
  output logic                o_dq_oe,
  output logic                o_dqs,
  output logic                o_dqs_oe,
  output logic                o_done,
  output logic                o_underrun
);

  localparam int unsigned BeatW = $clog2(BURST_LEN);
  localparam int unsigned MaskW = DATA_W / 8;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

  typedef enum logic [2:0] {StIdle, StWait, StPre, StBurst, StPost} state_e;

  state_e             r_state, w_state_d;
  logic [BeatW-1:0]   r_beat, w_beat_d;
  logic [WL_W-1:0]    r_lat;
  logic [DATA_W-1:0]  r_dq;
  logic [MaskW-1:0]   r_dm;
  logic               r_dqs;
  logic               r_underrun;
  logic               w_accept;
  logic               w_dqs_d;

  assign w_accept = i_cmd_valid && (r_state == StIdle);

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = (i_cmd_wl == '0) ? StPre : StWait;
        end
      end
      StWait:  if (r_lat == WL_W'(1)) w_state_d = StPre;
      StPre:   w_state_d = StBurst;
      StBurst: if (r_beat == LastBeat) w_state_d = StPost;
      StPost:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Output decode; cmd_ready is held low for as long as reset is asserted
  always_comb begin
    o_cmd_ready   = (r_state == StIdle) && i_reset;
    o_wdata_ready = (r_state == StPre) || ((r_state == StBurst) && (r_beat != LastBeat));
    o_dq_oe       = (r_state == StBurst);
    o_dqs_oe      = (r_state == StPre) || (r_state == StBurst) || (r_state == StPost);
    o_done        = (r_state == StPost);
  end

  assign w_beat_d = (r_state == StBurst) ? r_beat + 1'b1 : '0;
  // Strobe high on even beats so beat 0 starts on a rising edge
  assign w_dqs_d  = (w_state_d == StBurst) && !w_beat_d[0];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_beat     <= '0;
      r_lat      <= '0;
      r_dq       <= '0;
      r_dm       <= '0;
      r_dqs      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_beat <= w_beat_d;
      r_dqs  <= w_dqs_d;
      if (w_accept) begin
        r_lat <= i_cmd_wl;
      end else if (r_state == StWait) begin
        r_lat <= r_lat - 1'b1;
      end
      // A fetch without valid data sends a fully masked zero beat
      if (o_wdata_ready) begin
        r_dq <= i_wdata_valid ? i_wdata : '0;
        r_dm <= i_wdata_valid ? i_wmask : '1;
      end else begin
        r_dq <= '0;
        r_dm <= '0;
      end
      if (w_accept) begin
        r_underrun <= 1'b0;
      end else if (o_wdata_ready && !i_wdata_valid) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign o_dq       = r_dq;
  assign o_dm       = r_dm;
  assign o_dqs      = r_dqs;
  assign o_underrun = r_underrun;

endmodule
